comp_share_arbiter: RTL and testbench

- Shares one 32-bit comparator among NUM_REQ requesters, for example the ID-stage branch resolver and the EX-stage set-less-than path.
- Round-robin arbitration with a registered compare stage; one result per cycle at most.
- Supports stall and flush from the pipeline hazard unit.

---
 rtl/comp_share_if.sv | 29 ++
 rtl/comp_share_arbiter.sv | 126 ++++++++++++
 tb/tb_comp_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_share_if.sv
// Requester-side bus of the shared comparator: per-requester request/operand
// lanes in, one-hot grant and one-hot registered response out.
//   Handshake: requester i holds req[i] with stable operands until it sees
//   gnt[i]=1 in a cycle; the transfer happens in that cycle and it may drop or
//   replace the request on the next one. The response for that transfer
//   appears one cycle later as rsp_valid (one-hot owner) with rsp_res/rsp_err,
//   which are meaningful only while rsp_valid is nonzero and stall is low.
interface comp_share_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_op1;
  logic [NUM_REQ*32-1:0] req_op2;
  logic [NUM_REQ*3-1:0]  req_opc;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  rsp_res;
  logic                  rsp_err;

  modport master (
    output req, req_op1, req_op2, req_opc,
    input  gnt, rsp_valid, rsp_res, rsp_err
  );

  modport slave (
    input  req, req_op1, req_op2, req_opc,
    output gnt, rsp_valid, rsp_res, rsp_err
  );
endinterface

// File: rtl/comp_share_arbiter.sv
// comp_share_arbiter: one 32-bit comparator shared by NUM_REQ requesters.
// Round-robin grant (combinational, same cycle as req), operands captured at
// the grant edge, result driven from registers one cycle later.
// Optional macro COMP_SIGNED_EN adds signed gt (011) and signed lt (100);
// without it those codes are illegal and no signed compare is built.
module comp_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  comp_share_if.slave      bus,
  output logic             dbg_state,
  output logic [PTR_W-1:0] dbg_ptr
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } stage_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  stage_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rsp_res_q;
  logic                 rsp_err_q;

  logic [2*NUM_REQ-1:0] req_rot;
  logic                 found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     nxt_ptr;
  logic [NUM_REQ-1:0]   sel_vec;
  logic                 grant_en;
  logic [31:0]          op1;
  logic [31:0]          op2;
  logic [2:0]           opc;
  logic                 cmp_res;
  logic                 cmp_err;
  int                   win_tmp;

  // Rotate the request vector so the pointer lands on bit 0, then take the
  // first set bit; its offset from the pointer gives the winner index.
  always_comb begin
    req_rot = {bus.req, bus.req} >> ptr;
    found   = 1'b0;
    win_tmp = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_tmp = int'(ptr) + i;
        if (win_tmp >= NUM_REQ) win_tmp = win_tmp - NUM_REQ;
      end
    end
    win_idx = PTR_W'(win_tmp);
    nxt_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    sel_vec = ONE_HOT0 << win_idx;
  end

  // Stall and flush both suppress the grant; reset forces it low as well so
  // nothing is accepted while the stage cannot capture it.
  assign grant_en = rst_n && !stall && !flush && found;
  assign bus.gnt  = grant_en ? sel_vec : '0;

  // Operands of the winning requester feed the comparator directly, so the
  // registered result reflects the values present in the grant cycle.
  assign op1 = bus.req_op1[32*win_idx +: 32];
  assign op2 = bus.req_op2[32*win_idx +: 32];
  assign opc = bus.req_opc[3*win_idx +: 3];

  // Opcode decode and compare; unknown codes give res=0 with err=1.
  always_comb begin
    cmp_res = 1'b0;
    cmp_err = 1'b0;
    case (opc)
      3'b000:         cmp_res = (op1 == op2);
      3'b010:         cmp_res = (op1 > op2);
      3'b101, 3'b110: cmp_res = (op1 < op2);
`ifdef COMP_SIGNED_EN
      3'b011:         cmp_res = ($signed(op1) > $signed(op2));
      3'b100:         cmp_res = ($signed(op1) < $signed(op2));
`endif
      default:        cmp_err = 1'b1;
    endcase
  end

  // Stage FSM with pointer and registered response; flush beats stall,
  // stall freezes everything, otherwise a grant refills the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      ptr         <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      rsp_valid_q <= '0;
      rsp_res_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (!stall) begin
      if (found) begin
        state       <= ST_VALID;
        rsp_valid_q <= sel_vec;
        rsp_res_q   <= cmp_res;
        rsp_err_q   <= cmp_err;
        ptr         <= nxt_ptr;
      end else begin
        state       <= ST_EMPTY;
        rsp_valid_q <= '0;
        rsp_res_q   <= 1'b0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state;
  assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Testbench for comp_share_arbiter: directed scenarios followed by a
// randomized run checked against a queue-based reference model.
module tb_comp_share_arbiter;

  localparam int N     = 3;
  localparam int PTR_W = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic stall;
  logic flush;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  comp_share_if #(.NUM_REQ(N)) bus ();

  logic             dbg_state;
  logic [PTR_W-1:0] dbg_ptr;

  logic [N-1:0] req_v;
  logic [31:0]  op1_a [N];
  logic [31:0]  op2_a [N];
  logic [2:0]   opc_a [N];

  assign bus.req = req_v;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_op1[32*i +: 32] = op1_a[i];
      bus.req_op2[32*i +: 32] = op2_a[i];
      bus.req_opc[3*i +: 3]   = opc_a[i];
    end
  end

  comp_share_arbiter #(.NUM_REQ(N), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Expected stage content: at most one entry {owner one-hot, res, err}.
  logic [N+1:0] exp_q[$];
  int           m_ptr;

  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (a >= 32'h8000_0000) ? ua - 64'sd4294967296 : ua;
    longint sb = (b >= 32'h8000_0000) ? ub - 64'sd4294967296 : ub;
    case (c)
      3'd0:       return {(ua == ub), 1'b0};
      3'd2:       return {(ua > ub), 1'b0};
      3'd5, 3'd6: return {(ua < ub), 1'b0};
`ifdef COMP_SIGNED_EN
      3'd3:       return {(sa > sb), 1'b0};
      3'd4:       return {(sa < sb), 1'b0};
`endif
      default:    return 2'b01;
    endcase
  endfunction

  // First asserted requester scanning from the pointer, or -1 if none.
  function automatic int ref_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Applies one clock edge worth of spec rules to the model.
  task automatic model_edge();
    int w;
    w = ref_winner(req_v, m_ptr);
    if (flush) begin
      exp_q.delete();
    end else if (!stall) begin
      exp_q.delete();
      if (w >= 0) begin
        exp_q.push_back({N'(1) << w, ref_cmp(op1_a[w], op2_a[w], opc_a[w])});
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_v = '0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      op1_a[i] = '0;
      op2_a[i] = '0;
      opc_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_v = 3'b011;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
    checks++; if (bus.rsp_valid !== 3'b000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=000", bus.rsp_valid); end
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL reset_res_err got=%b exp=00", {bus.rsp_res, bus.rsp_err}); end
    checks++; if (dbg_ptr !== 3'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dbg_ptr); end
    do_reset();
  endtask

  task automatic test_basic_eq();
    do_reset();
    req_v = 3'b001; op1_a[0] = 32'd5; op2_a[0] = 32'd5; opc_a[0] = 3'b000;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL eq_gnt got=%b exp=001", bus.gnt); end
    next_cycle();
    req_v = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 3'b001) begin failures++; $display("FAIL eq_rsp_valid got=%b exp=001", bus.rsp_valid); end
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b10) begin failures++; $display("FAIL eq_res_err got=%b exp=10", {bus.rsp_res, bus.rsp_err}); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 3'b000) begin failures++; $display("FAIL eq_drain got=%b exp=000", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [N-1:0] prev_g;
    do_reset();
    req_v = 3'b011;
    for (int i = 0; i < 2; i++) begin
      op1_a[i] = 32'hFFFF_FFFF; op2_a[i] = 32'd1; opc_a[i] = 3'b010;
    end
    prev_g = '0;
    for (int c = 0; c < 4; c++) begin
      exp_g = (c % 2 == 0) ? 3'b001 : 3'b010;
      @(negedge clk);
      checks++; if (bus.gnt !== exp_g) begin failures++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, bus.gnt, exp_g); end
      if (c > 0) begin
        checks++; if ({bus.rsp_valid, bus.rsp_res, bus.rsp_err} !== {prev_g, 2'b10}) begin
          failures++; $display("FAIL rr_rsp cycle=%0d got=%b exp=%b", c, {bus.rsp_valid, bus.rsp_res, bus.rsp_err}, {prev_g, 2'b10});
        end
      end
      prev_g = exp_g;
      next_cycle();
    end
    req_v = '0;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_res} !== {3'b010, 1'b1}) begin failures++; $display("FAIL rr_last got=%b exp=0101", {bus.rsp_valid, bus.rsp_res}); end
  endtask

  task automatic test_stall();
    do_reset();
    req_v = 3'b001; op1_a[0] = 32'd3; op2_a[0] = 32'd7; opc_a[0] = 3'b110;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL stall_first_gnt got=%b exp=001", bus.gnt); end
    next_cycle();
    req_v = 3'b010; op1_a[1] = 32'd9; op2_a[1] = 32'd9; opc_a[1] = 3'b000; stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL stall_gnt cycle=%0d got=%b exp=000", c, bus.gnt); end
      checks++; if ({bus.rsp_valid, bus.rsp_res, bus.rsp_err} !== 5'b00110) begin
        failures++; $display("FAIL stall_hold cycle=%0d got=%b exp=00110", c, {bus.rsp_valid, bus.rsp_res, bus.rsp_err});
      end
      checks++; if (dbg_ptr !== 3'd1) begin failures++; $display("FAIL stall_ptr cycle=%0d got=%0d exp=1", c, dbg_ptr); end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL stall_release_gnt got=%b exp=010", bus.gnt); end
    next_cycle();
    req_v = '0;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_res} !== 4'b0101) begin failures++; $display("FAIL stall_after got=%b exp=0101", {bus.rsp_valid, bus.rsp_res}); end
  endtask

  task automatic test_flush();
    do_reset();
    req_v = 3'b001; op1_a[0] = 32'd1; op2_a[0] = 32'd1; opc_a[0] = 3'b000;
    opc_a[1] = 3'b000;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b001) begin failures++; $display("FAIL flush_first_gnt got=%b exp=001", bus.gnt); end
    next_cycle();
    req_v = 3'b011; flush = 1'b1; stall = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL flush_gnt got=%b exp=000", bus.gnt); end
    checks++; if (bus.rsp_valid !== 3'b001) begin failures++; $display("FAIL flush_cycle_rsp got=%b exp=001", bus.rsp_valid); end
    next_cycle();
    flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 3'b000) begin failures++; $display("FAIL flush_killed got=%b exp=000", bus.rsp_valid); end
    checks++; if (dbg_ptr !== 3'd1) begin failures++; $display("FAIL flush_ptr got=%0d exp=1", dbg_ptr); end
    checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL flush_next_gnt got=%b exp=010", bus.gnt); end
  endtask

  task automatic test_opcodes();
    do_reset();
    req_v = 3'b001; op1_a[0] = 32'h8000_0000; op2_a[0] = 32'd0; opc_a[0] = 3'b011;
    next_cycle();
    opc_a[0] = 3'b100;
    @(negedge clk);
`ifdef COMP_SIGNED_EN
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL sgt got=%b exp=00", {bus.rsp_res, bus.rsp_err}); end
`else
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b01) begin failures++; $display("FAIL sgt_illegal got=%b exp=01", {bus.rsp_res, bus.rsp_err}); end
`endif
    next_cycle();
    opc_a[0] = 3'b111;
    @(negedge clk);
`ifdef COMP_SIGNED_EN
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b10) begin failures++; $display("FAIL slt got=%b exp=10", {bus.rsp_res, bus.rsp_err}); end
`else
    checks++; if ({bus.rsp_res, bus.rsp_err} !== 2'b01) begin failures++; $display("FAIL slt_illegal got=%b exp=01", {bus.rsp_res, bus.rsp_err}); end
`endif
    next_cycle();
    req_v = '0;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_res, bus.rsp_err} !== 5'b00101) begin
      failures++; $display("FAIL illegal_111 got=%b exp=00101", {bus.rsp_valid, bus.rsp_res, bus.rsp_err});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v = 3'b001; op1_a[0] = 32'd2; op2_a[0] = 32'd2; opc_a[0] = 3'b000;
    next_cycle();
    req_v = 3'b011;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 3'b001) begin failures++; $display("FAIL midrst_inflight got=%b exp=001", bus.rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 3'b000) begin failures++; $display("FAIL midrst_drop got=%b exp=000", bus.rsp_valid); end
    checks++; if (bus.gnt !== 3'b000) begin failures++; $display("FAIL midrst_gnt got=%b exp=000", bus.gnt); end
    next_cycle();
    rst_n = 1'b1;
    req_v = 3'b110;
    @(negedge clk);
    checks++; if (dbg_ptr !== 3'd0) begin failures++; $display("FAIL midrst_ptr got=%0d exp=0", dbg_ptr); end
    checks++; if (bus.gnt !== 3'b010) begin failures++; $display("FAIL midrst_first_gnt got=%b exp=010", bus.gnt); end
    next_cycle();
    req_v = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 3'b010) begin failures++; $display("FAIL midrst_rsp got=%b exp=010", bus.rsp_valid); end
  endtask

  task automatic test_random();
    int           w;
    logic [N-1:0] exp_g;
    logic [N+1:0] exp_e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_v = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op1_a[i] = $urandom;
        case ($urandom_range(0, 3))
          0:       op2_a[i] = op1_a[i];
          1:       op2_a[i] = op1_a[i] ^ 32'h8000_0000;
          default: op2_a[i] = $urandom;
        endcase
        opc_a[i] = 3'($urandom_range(0, 7));
      end
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      w     = ref_winner(req_v, m_ptr);
      exp_g = (w >= 0 && !stall && !flush) ? N'(1) << w : '0;
      exp_e = (exp_q.size() > 0) ? exp_q[0] : '0;
      checks++; if (bus.gnt !== exp_g) begin failures++; $display("FAIL rnd_gnt cycle=%0d got=%b exp=%b", c, bus.gnt, exp_g); end
      checks++; if (bus.rsp_valid !== exp_e[N+1:2]) begin failures++; $display("FAIL rnd_rsp_valid cycle=%0d got=%b exp=%b", c, bus.rsp_valid, exp_e[N+1:2]); end
      if (exp_e[N+1:2] != '0) begin
        checks++; if ({bus.rsp_res, bus.rsp_err} !== exp_e[1:0]) begin
          failures++; $display("FAIL rnd_res_err cycle=%0d got=%b exp=%b", c, {bus.rsp_res, bus.rsp_err}, exp_e[1:0]);
        end
      end
      checks++; if (dbg_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL rnd_ptr cycle=%0d got=%0d exp=%0d", c, dbg_ptr, m_ptr); end
      @(posedge clk);
      model_edge();
      #1;
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    m_ptr = 0;
    clear_inputs();
    test_reset();
    test_basic_eq();
    test_round_robin();
    test_stall();
    test_flush();
    test_opcodes();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
